// File: rtl/bus_m_arbiter_pkg.sv
// Shared types and constants for the BUS_M three-requester arbiter.
// Optional starvation relief is built when BUS_M_ARB_STARVE_EN is defined.
package bus_m_arbiter_pkg;

   localparam logic [1:0] ARB_S0 = 2'd0;
   localparam logic [1:0] ARB_S1 = 2'd1;
   localparam logic [1:0] ARB_S2 = 2'd2;

   typedef enum logic {
      ARB_FREE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic        req;
      logic        seq;
      logic        cont;
      logic        lock;
      logic        write;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } arb_cmd_t;

   // Place a 4-bit {BUSERR, EXCEPTION, WRITE, DONE} group into requester slot idx.
   function automatic logic [11:0] done_steer(input logic [3:0] d, input logic [1:0] idx);
      done_steer = {8'b0, d} << {idx, 2'b00};
   endfunction

endpackage

// File: rtl/bus_m_arb_pri.sv
// Three-input priority encoder; rev=0 favours input 0, rev=1 favours input 2.
module bus_m_arb_pri
   import bus_m_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic       rev,
   output logic [1:0] idx,
   output logic       vld
);

   always_comb begin
      idx = ARB_S0;
      vld = |req;
      if (rev) begin
         if (req[2])      idx = ARB_S2;
         else if (req[1]) idx = ARB_S1;
         else             idx = ARB_S0;
      end else begin
         if (req[0])      idx = ARB_S0;
         else if (req[1]) idx = ARB_S1;
         else if (req[2]) idx = ARB_S2;
      end
   end

endmodule

// File: rtl/bus_m_arbiter.sv
// Shares the BUS_M command port between debug (S0), load/store (S1) and fetch (S2).
// Define BUS_M_ARB_STARVE_EN to add the reverse-priority starvation relief.
module bus_m_arbiter
   import bus_m_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        CLK,
   input  logic        RES_SYS_N,
   input  logic [2:0]  S_REQ,
   input  logic [2:0]  S_SEQ,
   input  logic [2:0]  S_CONT,
   input  logic [2:0]  S_LOCK,
   input  logic [2:0]  S_WRITE,
   input  logic [8:0]  S_BURST,
   input  logic [11:0] S_PROT,
   input  logic [5:0]  S_SIZE,
   input  logic [95:0] S_ADDR,
   input  logic [95:0] S_WDATA,
   output logic [2:0]  S_ACK,
   output logic [2:0]  S_LAST,
   output logic [11:0] S_DONE,
   output logic [11:0] S_DONE_RAW,
   output logic [31:0] S_RDATA,
   output logic [31:0] S_RDATA_RAW,
   output logic        BUS_M_REQ,
   output logic        BUS_M_SEQ,
   output logic        BUS_M_CONT,
   output logic [2:0]  BUS_M_BURST,
   output logic        BUS_M_LOCK,
   output logic [3:0]  BUS_M_PROT,
   output logic        BUS_M_WRITE,
   output logic [1:0]  BUS_M_SIZE,
   output logic [31:0] BUS_M_ADDR,
   output logic [31:0] BUS_M_WDATA,
   input  logic        BUS_M_ACK,
   input  logic        BUS_M_LAST,
   input  logic [3:0]  BUS_M_DONE,
   input  logic [3:0]  BUS_M_DONE_RAW,
   input  logic [31:0] BUS_M_RDATA,
   input  logic [31:0] BUS_M_RDATA_RAW,
   output arb_state_t  DBG_STATE
);

   // Handshake: BUS_M_REQ is the valid of the granted requester, BUS_M_ACK is the
   // bridge's ready; an address phase is accepted in the cycle both are high and
   // the requester sees it on S_ACK in that same cycle.

   arb_state_t state, state_nxt;
   logic [1:0] owner, owner_nxt;
   logic [1:0] dph_own, don_own;
   logic       dph_vld;
   logic [1:0] pri_idx, gnt;
   logic       pri_vld, gnt_vld, starve_flip, ack;
   arb_cmd_t   s_cmd [3];
   arb_cmd_t   sel;

   for (genvar i = 0; i < 3; i++) begin : g_cmd
      assign s_cmd[i] = '{req: S_REQ[i], seq: S_SEQ[i], cont: S_CONT[i], lock: S_LOCK[i],
                          write: S_WRITE[i], burst: S_BURST[3*i +: 3], prot: S_PROT[4*i +: 4],
                          size: S_SIZE[2*i +: 2], addr: S_ADDR[32*i +: 32],
                          wdata: S_WDATA[32*i +: 32]};
   end

   bus_m_arb_pri u_pri (
      .req (S_REQ),
      .rev (starve_flip),
      .idx (pri_idx),
      .vld (pri_vld)
   );

   assign gnt     = (state == ARB_HOLD) ? owner : pri_idx;
   assign gnt_vld = (state == ARB_HOLD) | pri_vld;
   assign ack     = BUS_M_ACK & gnt_vld;

   always_comb begin
      sel = '0;
      if (gnt_vld) begin
         case (gnt)
            ARB_S1:  sel = s_cmd[1];
            ARB_S2:  sel = s_cmd[2];
            default: sel = s_cmd[0];
         endcase
      end
   end

   assign BUS_M_REQ   = sel.req;
   assign BUS_M_SEQ   = sel.seq;
   assign BUS_M_CONT  = sel.cont;
   assign BUS_M_BURST = sel.burst;
   assign BUS_M_LOCK  = sel.lock;
   assign BUS_M_PROT  = sel.prot;
   assign BUS_M_WRITE = sel.write;
   assign BUS_M_SIZE  = sel.size;
   assign BUS_M_ADDR  = sel.addr;
   assign BUS_M_WDATA = sel.wdata;

   assign S_ACK       = ack ? (3'b001 << gnt) : 3'b000;
   assign S_LAST      = (BUS_M_LAST & dph_vld) ? (3'b001 << dph_own) : 3'b000;
   assign S_DONE_RAW  = done_steer(BUS_M_DONE_RAW, dph_own);
   assign S_DONE      = done_steer(BUS_M_DONE, don_own);
   assign S_RDATA     = BUS_M_RDATA;
   assign S_RDATA_RAW = BUS_M_RDATA_RAW;
   assign DBG_STATE   = state;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      case (state)
         ARB_FREE: begin
            if (ack && (sel.cont || sel.lock)) begin
               state_nxt = ARB_HOLD;
               owner_nxt = gnt;
            end
         end
         ARB_HOLD: begin
            // An owner that drops REQ, CONT and LOCK has abandoned its burst.
            if (!sel.cont && !sel.lock && (BUS_M_ACK || !sel.req))
               state_nxt = ARB_FREE;
         end
         default: state_nxt = ARB_FREE;
      endcase
   end

   always_ff @(posedge CLK or negedge RES_SYS_N) begin
      if (!RES_SYS_N) begin
         state   <= ARB_FREE;
         owner   <= ARB_S0;
         dph_own <= ARB_S0;
         dph_vld <= 1'b0;
         don_own <= ARB_S0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         if (BUS_M_LAST) don_own <= dph_own;
         // A new acknowledge takes the data phase even if the old one ends now.
         if (ack) begin
            dph_own <= gnt;
            dph_vld <= 1'b1;
         end else if (BUS_M_LAST) begin
            dph_vld <= 1'b0;
         end
      end
   end

`ifdef BUS_M_ARB_STARVE_EN
   logic [7:0] starve_cnt;
   logic       contended;

   assign starve_flip = (starve_cnt >= 8'(STARVE_LIMIT));
   assign contended   = |(S_REQ & ~(3'b001 << gnt));

   always_ff @(posedge CLK or negedge RES_SYS_N) begin
      if (!RES_SYS_N)
         starve_cnt <= 8'd0;
      else if (state == ARB_FREE && ack)
         starve_cnt <= (starve_flip || !contended) ? 8'd0 : starve_cnt + 8'd1;
   end
`else
   assign starve_flip = 1'b0;
`endif

endmodule

// File: tb/tb_bus_m_arbiter.sv
// Self-checking bench for bus_m_arbiter: directed scenarios plus random traffic
// against an index-level reference model (starvation checks with BUS_M_ARB_STARVE_EN).
module tb_bus_m_arbiter;
   import bus_m_arbiter_pkg::*;

`ifdef BUS_M_ARB_STARVE_EN
   localparam int LIMIT = 2;
`else
   localparam int LIMIT = 8;
`endif

   logic        CLK = 1'b0;
   logic        RES_SYS_N;
   logic [2:0]  S_REQ, S_SEQ, S_CONT, S_LOCK, S_WRITE;
   logic [8:0]  S_BURST;
   logic [11:0] S_PROT;
   logic [5:0]  S_SIZE;
   logic [95:0] S_ADDR, S_WDATA;
   logic [2:0]  S_ACK, S_LAST;
   logic [11:0] S_DONE, S_DONE_RAW;
   logic [31:0] S_RDATA, S_RDATA_RAW;
   logic        BUS_M_REQ, BUS_M_SEQ, BUS_M_CONT, BUS_M_LOCK, BUS_M_WRITE;
   logic [2:0]  BUS_M_BURST;
   logic [3:0]  BUS_M_PROT;
   logic [1:0]  BUS_M_SIZE;
   logic [31:0] BUS_M_ADDR, BUS_M_WDATA;
   logic        BUS_M_ACK, BUS_M_LAST;
   logic [3:0]  BUS_M_DONE, BUS_M_DONE_RAW;
   logic [31:0] BUS_M_RDATA, BUS_M_RDATA_RAW;
   arb_state_t  DBG_STATE;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: holder index (-1 = free), data-phase owner, done owner, starvation count
   int m_hold, m_dph, m_dvld, m_don, m_cnt;

   bus_m_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RES_SYS_N(RES_SYS_N),
      .S_REQ(S_REQ), .S_SEQ(S_SEQ), .S_CONT(S_CONT), .S_LOCK(S_LOCK), .S_WRITE(S_WRITE),
      .S_BURST(S_BURST), .S_PROT(S_PROT), .S_SIZE(S_SIZE), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA),
      .S_ACK(S_ACK), .S_LAST(S_LAST), .S_DONE(S_DONE), .S_DONE_RAW(S_DONE_RAW),
      .S_RDATA(S_RDATA), .S_RDATA_RAW(S_RDATA_RAW),
      .BUS_M_REQ(BUS_M_REQ), .BUS_M_SEQ(BUS_M_SEQ), .BUS_M_CONT(BUS_M_CONT),
      .BUS_M_BURST(BUS_M_BURST), .BUS_M_LOCK(BUS_M_LOCK), .BUS_M_PROT(BUS_M_PROT),
      .BUS_M_WRITE(BUS_M_WRITE), .BUS_M_SIZE(BUS_M_SIZE), .BUS_M_ADDR(BUS_M_ADDR),
      .BUS_M_WDATA(BUS_M_WDATA), .BUS_M_ACK(BUS_M_ACK), .BUS_M_LAST(BUS_M_LAST),
      .BUS_M_DONE(BUS_M_DONE), .BUS_M_DONE_RAW(BUS_M_DONE_RAW),
      .BUS_M_RDATA(BUS_M_RDATA), .BUS_M_RDATA_RAW(BUS_M_RDATA_RAW),
      .DBG_STATE(DBG_STATE)
   );

   always #5 CLK = ~CLK;

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      S_REQ = '0; S_SEQ = '0; S_CONT = '0; S_LOCK = '0; S_WRITE = '0;
      S_BURST = '0; S_PROT = '0; S_SIZE = '0; S_ADDR = '0; S_WDATA = '0;
      BUS_M_ACK = 1'b0; BUS_M_LAST = 1'b0; BUS_M_DONE = '0; BUS_M_DONE_RAW = '0;
      BUS_M_RDATA = '0; BUS_M_RDATA_RAW = '0;
   endtask

   task automatic apply_reset();
      RES_SYS_N = 1'b0;
      clear_inputs();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RES_SYS_N = 1'b1;
      m_hold = -1; m_dph = 0; m_dvld = 0; m_don = 0; m_cnt = 0;
   endtask

   // ---------------- reference model ----------------
   function automatic int model_gnt();
      bit flip;
      if (m_hold >= 0) return m_hold;
`ifdef BUS_M_ARB_STARVE_EN
      flip = (m_cnt >= LIMIT);
`else
      flip = 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
         int r;
         r = flip ? 2 - k : k;
         if (S_REQ[r]) return r;
      end
      return -1;
   endfunction

   task automatic model_step(input int g);
      bit acked;
      acked = BUS_M_ACK && (g >= 0);
      if (m_hold >= 0) begin
         if (!S_CONT[m_hold] && !S_LOCK[m_hold] && (BUS_M_ACK || !S_REQ[m_hold])) m_hold = -1;
      end else if (acked) begin
         if (S_CONT[g] || S_LOCK[g]) m_hold = g;
         if (m_cnt >= LIMIT) m_cnt = 0;
         else if ((S_REQ & ~(3'b001 << g)) != 3'b000) m_cnt = m_cnt + 1;
         else m_cnt = 0;
      end
      if (BUS_M_LAST) m_don = m_dph;
      if (acked) begin
         m_dph = g; m_dvld = 1;
      end else if (BUS_M_LAST) begin
         m_dvld = 0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      #1;
      n_cmp++;
      if ({S_ACK, S_LAST, BUS_M_REQ} !== 7'b0) begin
         n_err++; $display("FAIL reset_ack_last got=%b exp=0", {S_ACK, S_LAST, BUS_M_REQ});
      end
      n_cmp++;
      if ({S_DONE, S_DONE_RAW} !== 24'h0) begin
         n_err++; $display("FAIL reset_done got=%h exp=0", {S_DONE, S_DONE_RAW});
      end
      n_cmp++;
      if (BUS_M_ADDR !== 32'h0 || DBG_STATE !== ARB_FREE) begin
         n_err++; $display("FAIL reset_addr_state got=%h/%b exp=0/0", BUS_M_ADDR, DBG_STATE);
      end
   endtask

   task automatic test_priority();
      @(negedge CLK);
      clear_inputs();
      S_REQ = 3'b110; S_ADDR[63:32] = 32'h1111_0001; S_ADDR[95:64] = 32'h2222_0002;
      BUS_M_ACK = 1'b1;
      #1;
      n_cmp++;
      if (S_ACK !== 3'b010) begin
         n_err++; $display("FAIL prio_ack1 got=%b exp=010", S_ACK);
      end
      n_cmp++;
      if (BUS_M_ADDR !== 32'h1111_0001) begin
         n_err++; $display("FAIL prio_addr got=%h exp=11110001", BUS_M_ADDR);
      end
      @(negedge CLK);
      S_REQ = 3'b100;
      #1;
      n_cmp++;
      if (S_ACK !== 3'b100) begin
         n_err++; $display("FAIL prio_ack2 got=%b exp=100", S_ACK);
      end
      @(negedge CLK);
      clear_inputs();
   endtask

   task automatic test_burst();
      S_ADDR[95:64] = 32'hCAFE_0200; S_ADDR[31:0] = 32'hD0D0_0000;
      for (int b = 1; b <= 5; b++) begin
         @(negedge CLK);
         S_REQ     = (b == 1) ? 3'b100 : (b == 5) ? 3'b001 : 3'b101;
         S_CONT    = (b <= 3) ? 3'b100 : 3'b000;
         BUS_M_ACK = 1'b1;
         #1;
         n_cmp++;
         if (S_ACK !== ((b == 5) ? 3'b001 : 3'b100)) begin
            n_err++; $display("FAIL burst_ack beat=%0d got=%b exp=%b", b, S_ACK,
                              (b == 5) ? 3'b001 : 3'b100);
         end
      end
      @(negedge CLK);
      clear_inputs();
   endtask

   task automatic test_done();
      @(negedge CLK);
      S_REQ = 3'b010; BUS_M_ACK = 1'b1;
      @(negedge CLK);
      clear_inputs();
      BUS_M_LAST = 1'b1; BUS_M_DONE_RAW = 4'b0001;
      #1;
      n_cmp++;
      if (S_LAST !== 3'b010 || S_DONE_RAW !== 12'h010) begin
         n_err++; $display("FAIL done_last got=%b/%h exp=010/010", S_LAST, S_DONE_RAW);
      end
      @(negedge CLK);
      clear_inputs();
      BUS_M_DONE = 4'b0001;
      #1;
      n_cmp++;
      if (S_DONE !== 12'h010) begin
         n_err++; $display("FAIL done_slot got=%h exp=010", S_DONE);
      end
      @(negedge CLK);
      clear_inputs();
   endtask

   task automatic test_overlap();
      @(negedge CLK);
      S_REQ = 3'b010; BUS_M_ACK = 1'b1;
      @(negedge CLK);
      S_REQ = 3'b100; BUS_M_ACK = 1'b1; BUS_M_LAST = 1'b1;
      #1;
      n_cmp++;
      if (S_LAST !== 3'b010 || S_ACK !== 3'b100) begin
         n_err++; $display("FAIL ovl_same got=%b/%b exp=010/100", S_LAST, S_ACK);
      end
      @(negedge CLK);
      clear_inputs();
      BUS_M_LAST = 1'b1; BUS_M_DONE = 4'b0001;
      #1;
      n_cmp++;
      if (S_LAST !== 3'b100 || S_DONE !== 12'h010) begin
         n_err++; $display("FAIL ovl_s2_last got=%b/%h exp=100/010", S_LAST, S_DONE);
      end
      @(negedge CLK);
      clear_inputs();
      BUS_M_DONE = 4'b0001;
      #1;
      n_cmp++;
      if (S_DONE !== 12'h100) begin
         n_err++; $display("FAIL ovl_s2_done got=%h exp=100", S_DONE);
      end
      @(negedge CLK);
      clear_inputs();
   endtask

   task automatic test_reset_midxfer();
      @(negedge CLK);
      S_REQ = 3'b100; S_CONT = 3'b100; BUS_M_ACK = 1'b1;
      @(negedge CLK);
      S_REQ = 3'b000; BUS_M_LAST = 1'b1;
      #1;
      n_cmp++;
      if (S_ACK !== 3'b100 || S_LAST !== 3'b100 || DBG_STATE !== ARB_HOLD) begin
         n_err++; $display("FAIL midx_pre got=%b/%b/%b exp=100/100/1", S_ACK, S_LAST, DBG_STATE);
      end
      #1 RES_SYS_N = 1'b0;
      #1;
      n_cmp++;
      if (S_ACK !== 3'b000 || S_LAST !== 3'b000 || S_DONE !== 12'h0 || DBG_STATE !== ARB_FREE) begin
         n_err++; $display("FAIL midx_rst got=%b/%b/%h/%b exp=0/0/0/0", S_ACK, S_LAST, S_DONE, DBG_STATE);
      end
      clear_inputs();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RES_SYS_N = 1'b1;
      @(negedge CLK);
      S_REQ = 3'b011; BUS_M_ACK = 1'b1;
      #1;
      n_cmp++;
      if (S_ACK !== 3'b001) begin
         n_err++; $display("FAIL midx_after got=%b exp=001", S_ACK);
      end
      @(negedge CLK);
      clear_inputs();
   endtask

`ifdef BUS_M_ARB_STARVE_EN
   task automatic test_starve();
      logic [2:0] order [6];
      order = '{3'b010, 3'b010, 3'b100, 3'b010, 3'b010, 3'b100};
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         S_REQ = 3'b110; BUS_M_ACK = 1'b1;
         #1;
         n_cmp++;
         if (S_ACK !== order[k]) begin
            n_err++; $display("FAIL starve_order k=%0d got=%b exp=%b", k, S_ACK, order[k]);
         end
      end
      @(negedge CLK);
      clear_inputs();
   endtask
`endif

   task automatic test_random(input int cycles);
      int g;
      logic [2:0] e_ack, e_last;
      logic [31:0] e_addr, e_wdata;
      logic e_req;
      apply_reset();
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK);
         S_REQ = 3'($urandom_range(0, 7));
         for (int i = 0; i < 3; i++) begin
            S_CONT[i] = ($urandom_range(0, 3) == 0);
            S_LOCK[i] = ($urandom_range(0, 7) == 0);
            S_ADDR[32*i +: 32]  = $urandom();
            S_WDATA[32*i +: 32] = $urandom();
         end
         S_SEQ = 3'($urandom_range(0, 7)); S_WRITE = 3'($urandom_range(0, 7));
         S_BURST = 9'($urandom()); S_PROT = 12'($urandom()); S_SIZE = 6'($urandom());
         g = model_gnt();
         BUS_M_ACK = (g >= 0 && S_REQ[g]) ? 1'($urandom_range(0, 1)) : 1'b0;
         BUS_M_LAST = ($urandom_range(0, 2) == 0);
         BUS_M_DONE = 4'($urandom()); BUS_M_DONE_RAW = 4'($urandom());
         BUS_M_RDATA = $urandom(); BUS_M_RDATA_RAW = $urandom();
         e_ack   = (BUS_M_ACK && g >= 0) ? 3'(1 << g) : 3'b000;
         e_last  = (BUS_M_LAST && m_dvld != 0) ? 3'(1 << m_dph) : 3'b000;
         e_addr  = (g >= 0) ? S_ADDR[32*g +: 32] : 32'h0;
         e_wdata = (g >= 0) ? S_WDATA[32*g +: 32] : 32'h0;
         e_req   = (g >= 0) ? S_REQ[g] : 1'b0;
         #1;
         n_cmp++;
         if (S_ACK !== e_ack) begin
            n_err++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, S_ACK, e_ack);
         end
         n_cmp++;
         if (BUS_M_ADDR !== e_addr || BUS_M_WDATA !== e_wdata || BUS_M_REQ !== e_req) begin
            n_err++; $display("FAIL rnd_cmd cyc=%0d got=%h/%h/%b exp=%h/%h/%b", c,
                              BUS_M_ADDR, BUS_M_WDATA, BUS_M_REQ, e_addr, e_wdata, e_req);
         end
         n_cmp++;
         if (S_LAST !== e_last) begin
            n_err++; $display("FAIL rnd_last cyc=%0d got=%b exp=%b", c, S_LAST, e_last);
         end
         n_cmp++;
         if (S_DONE !== (12'(BUS_M_DONE) << (4*m_don)) ||
             S_DONE_RAW !== (12'(BUS_M_DONE_RAW) << (4*m_dph))) begin
            n_err++; $display("FAIL rnd_done cyc=%0d got=%h/%h exp=%h/%h", c, S_DONE, S_DONE_RAW,
                              12'(BUS_M_DONE) << (4*m_don), 12'(BUS_M_DONE_RAW) << (4*m_dph));
         end
         n_cmp++;
         if (S_RDATA !== BUS_M_RDATA || S_RDATA_RAW !== BUS_M_RDATA_RAW) begin
            n_err++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h", c, S_RDATA, S_RDATA_RAW);
         end
         @(posedge CLK);
         model_step(g);
      end
      @(negedge CLK);
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_burst();
      test_done();
      test_overlap();
      test_reset_midxfer();
`ifdef BUS_M_ARB_STARVE_EN
      test_starve();
`endif
      test_random(400);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
